// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: turns RAW hazards, taken branches and data-memory
// wait states into stall/flush controls, with a memory watchdog and perf counters.
module hazard_ctrl #(
    parameter bit          FORWARD_EN  = 1'b1,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [4:0]  ex_reg_wr_addr,
    input  logic        ex_reg_wr_en,
    input  logic        ex_mem_to_reg,
    input  logic [4:0]  mem_reg_wr_addr,
    input  logic        mem_reg_wr_en,
    input  logic        ex_branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_wr_en,
    output logic        ifid_wr_en,
    output logic        idex_wr_en,
    output logic        exmem_wr_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        memwb_flush,
    output logic        mem_err,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        ERR
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        mem_err_q, mem_err_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic hz_ex, hz_mem, raw_stall, mem_wait;

    // Register 0 is hardwired, so a zero destination never creates a dependence.
    always_comb begin
        hz_ex  = ex_reg_wr_en && (ex_reg_wr_addr != 5'd0) &&
                 ((id_uses_rs && (id_rs_addr == ex_reg_wr_addr)) ||
                  (id_uses_rt && (id_rt_addr == ex_reg_wr_addr)));
        hz_mem = mem_reg_wr_en && (mem_reg_wr_addr != 5'd0) &&
                 ((id_uses_rs && (id_rs_addr == mem_reg_wr_addr)) ||
                  (id_uses_rt && (id_rt_addr == mem_reg_wr_addr)));
        if (FORWARD_EN) begin
            raw_stall = hz_ex && ex_mem_to_reg;
        end else begin
            raw_stall = hz_ex || hz_mem;
        end
        mem_wait = dmem_req && !dmem_ready;
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            RUN: begin
                if (mem_wait) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd0;
                end
            end
            MEM_WAIT: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                // A completion in the timeout cycle wins over the watchdog.
                if (dmem_ready) begin
                    state_d = RUN;
                end else if ((wait_cnt_q == TIMEOUT_LAST) && mem_wait) begin
                    state_d   = ERR;
                    mem_err_d = 1'b1;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        pc_wr_en    = 1'b1;
        ifid_wr_en  = 1'b1;
        idex_wr_en  = 1'b1;
        exmem_wr_en = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        if (rst) begin
            pc_wr_en    = 1'b0;
            ifid_wr_en  = 1'b0;
            idex_wr_en  = 1'b0;
            exmem_wr_en = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
        end else if (mem_wait || (state_q == ERR)) begin
            pc_wr_en    = 1'b0;
            ifid_wr_en  = 1'b0;
            idex_wr_en  = 1'b0;
            exmem_wr_en = 1'b0;
            memwb_flush = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (raw_stall) begin
            pc_wr_en   = 1'b0;
            ifid_wr_en = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_wr_en && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (ifid_flush && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= 8'd0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with forwarding, one without,
// both sharing the same stimulus and a 4-cycle memory timeout.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs_addr, id_rt_addr, ex_reg_wr_addr, mem_reg_wr_addr;
    logic       id_uses_rs, id_uses_rt, ex_reg_wr_en, ex_mem_to_reg, mem_reg_wr_en;
    logic       ex_branch_taken, dmem_req, dmem_ready;

    logic        pc_f, ifid_f, idex_f, exmem_f, ifidfl_f, idexfl_f, memwbfl_f, err_f;
    logic [15:0] stall_f, flush_f;
    logic        pc_n, ifid_n, idex_n, exmem_n, ifidfl_n, idexfl_n, memwbfl_n, err_n;
    logic [15:0] stall_n, flush_n;

    int total = 0;
    int bad   = 0;

    // Control bundle: {pc, ifid, idex, exmem, ifid_flush, idex_flush, memwb_flush}
    localparam logic [6:0] C_RUN    = 7'b1111000;
    localparam logic [6:0] C_RESET  = 7'b0000111;
    localparam logic [6:0] C_STALL  = 7'b0011010;
    localparam logic [6:0] C_BRANCH = 7'b1111110;
    localparam logic [6:0] C_FREEZE = 7'b0000001;

    logic [6:0] ctl_f, ctl_n;
    assign ctl_f = {pc_f, ifid_f, idex_f, exmem_f, ifidfl_f, idexfl_f, memwbfl_f};
    assign ctl_n = {pc_n, ifid_n, idex_n, exmem_n, ifidfl_n, idexfl_n, memwbfl_n};

    always #5 clk = ~clk;

    hazard_ctrl #(.FORWARD_EN(1'b1), .MEM_TIMEOUT(4)) dut_fwd (
        .clk(clk), .rst(rst),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_reg_wr_addr(ex_reg_wr_addr), .ex_reg_wr_en(ex_reg_wr_en),
        .ex_mem_to_reg(ex_mem_to_reg),
        .mem_reg_wr_addr(mem_reg_wr_addr), .mem_reg_wr_en(mem_reg_wr_en),
        .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_wr_en(pc_f), .ifid_wr_en(ifid_f), .idex_wr_en(idex_f), .exmem_wr_en(exmem_f),
        .ifid_flush(ifidfl_f), .idex_flush(idexfl_f), .memwb_flush(memwbfl_f),
        .mem_err(err_f), .stall_cnt(stall_f), .flush_cnt(flush_f)
    );

    hazard_ctrl #(.FORWARD_EN(1'b0), .MEM_TIMEOUT(4)) dut_nofwd (
        .clk(clk), .rst(rst),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_reg_wr_addr(ex_reg_wr_addr), .ex_reg_wr_en(ex_reg_wr_en),
        .ex_mem_to_reg(ex_mem_to_reg),
        .mem_reg_wr_addr(mem_reg_wr_addr), .mem_reg_wr_en(mem_reg_wr_en),
        .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_wr_en(pc_n), .ifid_wr_en(ifid_n), .idex_wr_en(idex_n), .exmem_wr_en(exmem_n),
        .ifid_flush(ifidfl_n), .idex_flush(idexfl_n), .memwb_flush(memwbfl_n),
        .mem_err(err_n), .stall_cnt(stall_n), .flush_cnt(flush_n)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_reg_wr_addr = 5'd0; ex_reg_wr_en = 1'b0; ex_mem_to_reg = 1'b0;
        mem_reg_wr_addr = 5'd0; mem_reg_wr_en = 1'b0;
        ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        step();
        @(negedge clk);
        total++;
        if (ctl_f !== C_RESET) begin
            bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl_f, C_RESET);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (ctl_f !== C_RUN) begin
            bad++; $display("FAIL post_reset_ctl got=%b exp=%b", ctl_f, C_RUN);
        end
        total++;
        if ({err_f, stall_f, flush_f} !== 33'd0) begin
            bad++; $display("FAIL post_reset_regs got err=%0d stall=%0d flush=%0d exp all 0",
                            err_f, stall_f, flush_f);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_reg_wr_en = 1'b1; ex_reg_wr_addr = 5'd5; ex_mem_to_reg = 1'b1;
        id_uses_rs = 1'b1; id_rs_addr = 5'd5;
        @(negedge clk);
        total++;
        if (ctl_f !== C_STALL) begin
            bad++; $display("FAIL load_use_stall got=%b exp=%b", ctl_f, C_STALL);
        end
        step();
        ex_reg_wr_en = 1'b0; ex_mem_to_reg = 1'b0;
        mem_reg_wr_en = 1'b1; mem_reg_wr_addr = 5'd5;
        @(negedge clk);
        total++;
        if (ctl_f !== C_RUN) begin
            bad++; $display("FAIL load_use_resume got=%b exp=%b", ctl_f, C_RUN);
        end
        total++;
        if (stall_f !== 16'd1) begin
            bad++; $display("FAIL load_use_stall_cnt got=%0d exp=1", stall_f);
        end
        step();
        set_idle();
        @(negedge clk);
        total++;
        if (stall_f !== 16'd1) begin
            bad++; $display("FAIL load_use_stall_cnt_hold got=%0d exp=1", stall_f);
        end
    endtask

    task automatic test_rtype_fwd();
        do_reset();
        ex_reg_wr_en = 1'b1; ex_reg_wr_addr = 5'd5; ex_mem_to_reg = 1'b0;
        id_uses_rs = 1'b1; id_rs_addr = 5'd5;
        @(negedge clk);
        total++;
        if (ctl_f !== C_RUN) begin
            bad++; $display("FAIL rtype_fwd_ctl got=%b exp=%b", ctl_f, C_RUN);
        end
        total++;
        if (ctl_n !== C_STALL) begin
            bad++; $display("FAIL rtype_nofwd_ctl got=%b exp=%b", ctl_n, C_STALL);
        end
        step();
        ex_reg_wr_addr = 5'd0; ex_mem_to_reg = 1'b1;
        mem_reg_wr_en = 1'b1; mem_reg_wr_addr = 5'd0;
        id_uses_rt = 1'b1; id_rs_addr = 5'd0; id_rt_addr = 5'd0;
        @(negedge clk);
        total++;
        if ({ctl_f, ctl_n} !== {C_RUN, C_RUN}) begin
            bad++; $display("FAIL reg0_no_hazard got=%b/%b exp=%b/%b", ctl_f, ctl_n, C_RUN, C_RUN);
        end
    endtask

    task automatic test_no_forward();
        do_reset();
        ex_reg_wr_en = 1'b1; ex_reg_wr_addr = 5'd7;
        id_uses_rt = 1'b1; id_rt_addr = 5'd7; id_uses_rs = 1'b1; id_rs_addr = 5'd3;
        @(negedge clk);
        total++;
        if ({ctl_n, ctl_f} !== {C_STALL, C_RUN}) begin
            bad++; $display("FAIL nofwd_ex_dep got=%b/%b exp=%b/%b", ctl_n, ctl_f, C_STALL, C_RUN);
        end
        step();
        ex_reg_wr_en = 1'b0; ex_reg_wr_addr = 5'd0;
        mem_reg_wr_en = 1'b1; mem_reg_wr_addr = 5'd7;
        @(negedge clk);
        total++;
        if ({ctl_n, ctl_f} !== {C_STALL, C_RUN}) begin
            bad++; $display("FAIL nofwd_mem_dep got=%b/%b exp=%b/%b", ctl_n, ctl_f, C_STALL, C_RUN);
        end
        step();
        mem_reg_wr_en = 1'b0; mem_reg_wr_addr = 5'd0;
        @(negedge clk);
        total++;
        if (ctl_n !== C_RUN) begin
            bad++; $display("FAIL nofwd_resume got=%b exp=%b", ctl_n, C_RUN);
        end
        total++;
        if ({stall_n, stall_f} !== {16'd2, 16'd0}) begin
            bad++; $display("FAIL nofwd_stall_cnt got=%0d/%0d exp=2/0", stall_n, stall_f);
        end
    endtask

    task automatic test_branch();
        do_reset();
        ex_reg_wr_en = 1'b1; ex_reg_wr_addr = 5'd9; ex_mem_to_reg = 1'b1;
        id_uses_rs = 1'b1; id_rs_addr = 5'd9; ex_branch_taken = 1'b1;
        @(negedge clk);
        total++;
        if ({ctl_f, ctl_n} !== {C_BRANCH, C_BRANCH}) begin
            bad++; $display("FAIL branch_over_raw got=%b/%b exp=%b", ctl_f, ctl_n, C_BRANCH);
        end
        step();
        set_idle();
        @(negedge clk);
        total++;
        if ({flush_f, stall_f} !== {16'd1, 16'd0}) begin
            bad++; $display("FAIL branch_counters got flush=%0d stall=%0d exp flush=1 stall=0",
                            flush_f, stall_f);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (ctl_f !== C_FREEZE) begin
                bad++; $display("FAIL mem_wait_freeze%0d got=%b exp=%b", i, ctl_f, C_FREEZE);
            end
            step();
        end
        dmem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (ctl_f !== C_BRANCH) begin
            bad++; $display("FAIL mem_ready_branch got=%b exp=%b", ctl_f, C_BRANCH);
        end
        step();
        set_idle();
        dmem_req = 1'b1; dmem_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({ctl_f, err_f, stall_f, flush_f} !== {C_RUN, 1'b0, 16'd3, 16'd1}) begin
            bad++; $display("FAIL mem_wait_after got ctl=%b err=%0d stall=%0d flush=%0d exp ctl=%b err=0 stall=3 flush=1",
                            ctl_f, err_f, stall_f, flush_f, C_RUN);
        end
    endtask

    task automatic test_timeout_race();
        do_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        dmem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (ctl_f !== C_RUN) begin
            bad++; $display("FAIL race_ready_ctl got=%b exp=%b", ctl_f, C_RUN);
        end
        step();
        set_idle();
        @(negedge clk);
        total++;
        if ({ctl_f, err_f, stall_f} !== {C_RUN, 1'b0, 16'd4}) begin
            bad++; $display("FAIL race_no_err got ctl=%b err=%0d stall=%0d exp ctl=%b err=0 stall=4",
                            ctl_f, err_f, stall_f, C_RUN);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        @(negedge clk);
        total++;
        if ({err_f, err_n} !== 2'b11) begin
            bad++; $display("FAIL timeout_err got=%b%b exp=11", err_f, err_n);
        end
        step();
        set_idle();
        @(negedge clk);
        total++;
        if ({ctl_f, err_f, stall_f} !== {C_FREEZE, 1'b1, 16'd6}) begin
            bad++; $display("FAIL err_frozen got ctl=%b err=%0d stall=%0d exp ctl=%b err=1 stall=6",
                            ctl_f, err_f, stall_f, C_FREEZE);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (ctl_f !== C_RESET) begin
            bad++; $display("FAIL err_reset_ctl got=%b exp=%b", ctl_f, C_RESET);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({ctl_f, err_f, stall_f, flush_f} !== {C_RUN, 1'b0, 16'd0, 16'd0}) begin
            bad++; $display("FAIL err_cleared got ctl=%b err=%0d stall=%0d flush=%0d exp ctl=%b err=0 stall=0 flush=0",
                            ctl_f, err_f, stall_f, flush_f, C_RUN);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        test_reset();
        test_load_use();
        test_rtype_fwd();
        test_no_forward();
        test_branch();
        test_mem_wait();
        test_timeout_race();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
